// File: rtl/pll_lock_rst_gen.sv
// PLL lock qualifier and domain reset generator: synchronizes the async lock flag,
// releases a registered active-low reset after stable lock, and counts lock losses.
module pll_lock_rst_gen #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER        = 4,
    parameter int RST_HOLD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       rst_sync_n,
    output logic       ready,
    output logic       lock_lost_pulse,
    output logic [7:0] lock_lost_cnt,
    output logic [1:0] state
);

    // state     | meaning
    // WAIT_LOCK | domain held in reset, waiting for synchronized lock
    // STABILIZE | lock seen, counting consecutive locked cycles
    // RUN       | reset released, filtering for lock loss
    // HOLD      | software-requested reset pulse, loss filtering still active
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        STABILIZE = 2'b01,
        RUN       = 2'b10,
        HOLD      = 2'b11
    } state_t;

    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int LOSS_W = $clog2(LOSS_FILTER + 1);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    state_t            state_q, state_nxt;
    logic [STAB_W-1:0] stab_cnt, stab_nxt;
    logic [LOSS_W-1:0] loss_cnt, loss_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              loss_evt;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q          <= '0;
            state_q         <= WAIT_LOCK;
            stab_cnt        <= '0;
            loss_cnt        <= '0;
            hold_cnt        <= '0;
            rst_sync_n      <= 1'b0;
            ready           <= 1'b0;
            lock_lost_pulse <= 1'b0;
            lock_lost_cnt   <= 8'd0;
        end else begin
            sync_q          <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            state_q         <= state_nxt;
            stab_cnt        <= stab_nxt;
            loss_cnt        <= loss_nxt;
            hold_cnt        <= hold_nxt;
            rst_sync_n      <= (state_nxt == RUN);
            ready           <= (state_nxt == RUN);
            lock_lost_pulse <= loss_evt;
            if (loss_evt && (lock_lost_cnt != 8'hFF)) begin
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        stab_nxt  = stab_cnt;
        loss_nxt  = loss_cnt;
        hold_nxt  = hold_cnt;
        loss_evt  = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                loss_nxt = '0;
                if (lock_s) begin
                    state_nxt = STABILIZE;
                    stab_nxt  = '0;
                end
            end
            STABILIZE: begin
                loss_nxt = '0;
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nxt = RUN;
                end else begin
                    stab_nxt = stab_cnt + 1'b1;
                end
            end
            RUN, HOLD: begin
                if (lock_s) begin
                    loss_nxt = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    loss_evt  = 1'b1;
                    loss_nxt  = '0;
                    state_nxt = WAIT_LOCK;
                end else begin
                    loss_nxt = loss_cnt + 1'b1;
                end
                // A qualified loss outranks both a new soft request and hold expiry
                if (!loss_evt) begin
                    if (state_q == RUN) begin
                        if (soft_rst_req) begin
                            state_nxt = HOLD;
                            hold_nxt  = '0;
                        end
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Self-checking bench for pll_lock_rst_gen: directed scenarios plus random lock/soft
// traffic, compared every cycle against a run-length based reference model.
module tb_pll_lock_rst_gen;

    localparam int S = 2;
    localparam int L = 16;
    localparam int F = 4;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       rst_sync_n;
    logic       ready;
    logic       lock_lost_pulse;
    logic [7:0] lock_lost_cnt;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    pll_lock_rst_gen #(
        .SYNC_STAGES(S),
        .LOCK_STABLE_CYCLES(L),
        .LOSS_FILTER(F),
        .RST_HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .soft_rst_req(soft_rst_req),
        .rst_sync_n(rst_sync_n),
        .ready(ready),
        .lock_lost_pulse(lock_lost_pulse),
        .lock_lost_cnt(lock_lost_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: lock_s is pll_lock delayed S edges; before RUN the domain is
    // described by the length of the current run of synchronized highs, in RUN/HOLD
    // by the length of the current run of lows and the remaining hold cycles.
    logic    m_pipe[S];
    int      m_hi, m_lo, m_hold_left, m_cnt;
    bit      m_running, m_holding, m_pulse;

    function automatic void model_reset();
        for (int i = 0; i < S; i++) m_pipe[i] = 1'b0;
        m_hi = 0; m_lo = 0; m_hold_left = 0; m_cnt = 0;
        m_running = 0; m_holding = 0; m_pulse = 0;
    endfunction

    function automatic void model_step(input logic lk, input logic sr);
        logic ls;
        ls = m_pipe[S-1];
        for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = lk;
        m_pulse = 0;
        if (!m_running) begin
            m_hi = ls ? m_hi + 1 : 0;
            m_lo = 0;
            // one edge to enter STABILIZE, then L more locked edges to release
            if (m_hi > L) begin
                m_running = 1;
                m_holding = 0;
            end
        end else begin
            m_lo = ls ? 0 : m_lo + 1;
            if (m_lo == F) begin
                m_running = 0; m_holding = 0;
                m_hi = 0; m_lo = 0;
                m_pulse = 1;
                if (m_cnt < 255) m_cnt++;
            end else if (!m_holding) begin
                if (sr) begin
                    m_holding = 1;
                    m_hold_left = H;
                end
            end else begin
                m_hold_left--;
                if (m_hold_left == 0) m_holding = 0;
            end
        end
    endfunction

    function automatic logic [1:0] model_state();
        if (m_running) return m_holding ? 2'd3 : 2'd2;
        return (m_hi == 0) ? 2'd0 : 2'd1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic run_exp;
        run_exp = m_running && !m_holding;
        chk("rst_sync_n", 8'(rst_sync_n), 8'(run_exp));
        chk("ready", 8'(ready), 8'(run_exp));
        chk("lock_lost_pulse", 8'(lock_lost_pulse), 8'(m_pulse));
        chk("lock_lost_cnt", lock_lost_cnt, 8'(m_cnt));
        chk("state", 8'(state), 8'(model_state()));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(pll_lock, soft_rst_req);
        #1;
        chk_all();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (rst_sync_n === 1'b1) break;
        end
        chk("wait_ready_reached", 8'(rst_sync_n), 8'd1);
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic one_loss();
        int n;
        pll_lock = 1'b0;
        repeat (6) tick();
        pll_lock = 1'b1;
        wait_ready(n);
    endtask

    initial begin
        int n;
        model_reset();

        // Power-up
        repeat (5) tick();
        rst_n = 1'b1;
        pll_lock = 1'b1;
        wait_ready(n);
        chk("powerup_release_edge", 8'(n), 8'd19);
        chk("powerup_cnt", lock_lost_cnt, 8'd0);

        // Unstable lock
        sync_reset();
        pll_lock = 1'b1;
        repeat (10) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("unstable_state_wait", 8'(state), 8'd0);
        pll_lock = 1'b1;
        wait_ready(n);
        chk("unstable_release_edge", 8'(n), 8'd19);
        chk("unstable_cnt", lock_lost_cnt, 8'd0);

        // Glitch rejection then a qualified loss
        pll_lock = 1'b0;
        repeat (3) tick();
        pll_lock = 1'b1;
        repeat (10) tick();
        chk("glitch_rst_sync_n", 8'(rst_sync_n), 8'd1);
        chk("glitch_cnt", lock_lost_cnt, 8'd0);
        pll_lock = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (lock_lost_pulse === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("loss_pulse_edge", 8'(n), 8'd6);
        chk("loss_cnt", lock_lost_cnt, 8'd1);
        pll_lock = 1'b1;
        wait_ready(n);

        // Soft reset with a second request during the hold
        soft_rst_req = 1'b1;
        tick();
        n = 1;
        for (int i = 1; i <= 40; i++) begin
            soft_rst_req = (i == 5);
            tick();
            if (rst_sync_n === 1'b1) break;
            n++;
        end
        soft_rst_req = 1'b0;
        chk("soft_hold_len", 8'(n), 8'd16);

        // Random lock/soft traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) pll_lock = ~pll_lock;
            soft_rst_req = ($urandom_range(15) == 0);
            tick();
        end
        soft_rst_req = 1'b0;
        pll_lock = 1'b1;
        repeat (3) tick();
        wait_ready(n);

        // Saturation
        for (int i = 0; i < 256; i++) one_loss();
        chk("sat_cnt", lock_lost_cnt, 8'd255);

        // Loss and soft request on the same edge
        pll_lock = 1'b0;
        repeat (5) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk("prio_state", 8'(state), 8'd0);
        chk("prio_pulse", 8'(lock_lost_pulse), 8'd1);
        chk("prio_cnt", lock_lost_cnt, 8'd255);
        pll_lock = 1'b1;
        wait_ready(n);

        // Async reset mid-RUN with count 3
        sync_reset();
        pll_lock = 1'b1;
        wait_ready(n);
        repeat (3) one_loss();
        chk("async_pre_cnt", lock_lost_cnt, 8'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        chk("async_cnt_zero", lock_lost_cnt, 8'd0);
        chk("async_rst_sync_n", 8'(rst_sync_n), 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (25) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_rst_gen.md
Name: pll_lock_rst_gen

Overview:
Downstream companion of the board PLL. Runs in the PLL output clock domain (199.8 MHz system clock) and consumes the PLL's asynchronous lock flag. It qualifies lock stability, then releases a synchronously-deasserted active-low reset to all logic in that domain. It also detects and counts lock-loss events and supports a software-requested reset pulse.

Parameters:
SYNC_STAGES, 2, number of flops in the pll_lock synchronizer (legal range >=2)
LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronized lock required before reset release (>=1)
LOSS_FILTER, 4, consecutive cycles of synchronized lock low required to declare loss (>=1)
RST_HOLD_CYCLES, 16, exact reset-low duration for a soft reset request (>=1)

Ports:
clk  input  1  PLL output clock; all flops on rising edge
rst_n  input  1  asynchronous active-low reset; asserts immediately, no internal deassert sync required
pll_lock  input  1  PLL lock flag, asynchronous to clk
soft_rst_req  input  1  synchronous request, sampled every cycle
rst_sync_n  output  1  registered active-low domain reset; 1 only in RUN
ready  output  1  registered, identical timing to rst_sync_n
lock_lost_pulse  output  1  one-cycle pulse per declared lock loss
lock_lost_cnt  output  8  saturating count of declared lock losses
state  output  2  FSM state code, for debug/status

Behaviour:
- Reset (rst_n=0): state=WAIT_LOCK (00), rst_sync_n=0, ready=0, lock_lost_pulse=0, lock_lost_cnt=0, synchronizer flops=0, all internal counters=0.
- Synchronizer: pll_lock passes through SYNC_STAGES flops, giving lock_s. Edge 1 is the first capture of 1, so lock_s=1 after edge SYNC_STAGES.
- Stability counter width is $clog2(LOCK_STABLE_CYCLES+1). Loss and hold counters are sized likewise.
- WAIT_LOCK (00): rst_sync_n=0. If lock_s=1, go to STABILIZE with stab_cnt=0.
- STABILIZE (01): rst_sync_n=0.
  - If lock_s=0: go to WAIT_LOCK. No loss is counted here.
  - Else if stab_cnt==LOCK_STABLE_CYCLES-1: go to RUN.
  - Otherwise stab_cnt++.
  - Result: RUN, rst_sync_n=1 and ready=1 on the same edge, at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES after pll_lock rises.
- RUN (10): rst_sync_n=1, ready=1.
  - Loss counter: counts consecutive cycles with lock_s=0 and clears on lock_s=1.
  - On the LOSS_FILTER-th consecutive low cycle: go to WAIT_LOCK. rst_sync_n=0, ready=0, lock_lost_pulse=1 (one cycle), lock_lost_cnt++ saturating at 255, all on the same edge.
  - Latency from the pll_lock fall is SYNC_STAGES+LOSS_FILTER edges.
  - Low glitches shorter than LOSS_FILTER cycles have no effect.
- Soft reset: soft_rst_req=1 in RUN goes to HOLD (11) on that edge with rst_sync_n=0 and hold_cnt=0. HOLD lasts exactly RST_HOLD_CYCLES cycles, then returns to RUN.
- HOLD (11):
  - soft_rst_req is ignored; the hold is not extended.
  - Loss filtering continues as in RUN. A qualified loss goes to WAIT_LOCK and is counted and pulsed.
- Simultaneous events in RUN: a qualified loss and soft_rst_req on the same cycle resolve as loss (WAIT_LOCK, counted).
- soft_rst_req in WAIT_LOCK or STABILIZE: ignored.
- Reset mid-operation: rst_n assertion forces the reset values immediately in any state. The count is cleared.
- No combinational path from any input to any output.

Test Plan:
- Power-up: SYNC_STAGES=2, LOCK_STABLE_CYCLES=16. Hold rst_n=0 for 5 cycles, then release, then raise pll_lock before edge 1 -> rst_sync_n/ready rise at edge 19, state 00->01->10, lock_lost_cnt=0.
- Unstable lock: pll_lock high for 10 cycles, low for 3, then high steadily -> returns to WAIT_LOCK, no pulse, cnt=0; RUN is reached 19 edges after the second rise.
- Glitch rejection: LOSS_FILTER=4 in RUN, pll_lock low for 3 cycles -> rst_sync_n stays 1, no pulse. Low for 4 cycles -> rst_sync_n=0 and lock_lost_pulse=1 at edge 6 after the fall, cnt=1.
- Soft reset: RST_HOLD_CYCLES=16, soft_rst_req pulsed in RUN plus a second pulse 5 cycles later -> rst_sync_n low for exactly 16 cycles, then RUN.
- Saturation and priority: force 256 qualified losses -> cnt=255 and holds. Loss qualifying on the same cycle as soft_rst_req -> WAIT_LOCK, pulse=1.
- Async reset mid-RUN: assert rst_n between edges with cnt=3 -> all outputs reach reset values without a clock edge, cnt=0.
